mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency backing memory between the instruction-fetch stage (IF) and the data-memory stage (MEM) of the 5-stage pipelined CPU.
- Sequences each access through a req/ack handshake to the memory.
- Generates per-requester stall signals that freeze the pipeline registers while an access is pending.
- Adds starvation protection and a timeout error trap.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width.
- TIMEOUT, 255, number of BUSY cycles without m_ack_i before the arbiter enters ERR.
- STARVE_MAX, 4, number of consecutive MEM grants, with if_req_i pending, after which IF is forced a grant.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- if_req_i  in  1  fetch request, level; held until if_valid_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_rdata_o  out  DATA_W  fetched instruction.
- if_valid_o  out  1  one-cycle completion pulse.
- if_stall_o  out  1  if_req_i & ~if_valid_o (combinational).
- mem_req_i  in  1  data request, level; held until mem_valid_o.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_addr_i  in  ADDR_W  data address.
- mem_wdata_i  in  DATA_W  store data.
- mem_rdata_o  out  DATA_W  load data.
- mem_valid_o  out  1  one-cycle completion pulse.
- mem_stall_o  out  1  mem_req_i & ~mem_valid_o (combinational).
- m_req_o  out  1  backing-memory request.
- m_we_o  out  1  backing-memory write enable.
- m_addr_o  out  ADDR_W  backing-memory address.
- m_wdata_o  out  DATA_W  backing-memory write data.
- m_rdata_i  in  DATA_W  backing-memory read data, valid with m_ack_i.
- m_ack_i  in  1  backing-memory completion.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs except the combinational stalls are 0.
  - rdata registers, timeout counter and starvation counter are 0.
  - Any m_ack_i arriving after reset while in IDLE is ignored.
- FSM states: IDLE, BUSY, RESP, ERR.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise pick the grant:
    - MEM wins when both request (older instruction), unless starve_cnt == STARVE_MAX, in which case IF wins.
    - Latch grant, address, we and wdata into registers; go to BUSY.
  - IF grants drive m_we_o=0.
- BUSY:
  - m_req_o=1; m_addr_o, m_we_o, m_wdata_o are stable from the latched registers.
  - m_ack_i=1: capture m_rdata_i into the granted requester's rdata register (loads and fetches only; a store leaves mem_rdata_o unchanged); go to RESP.
  - m_ack_i=0: increment tmo_cnt; when tmo_cnt reaches TIMEOUT, go to ERR.
- RESP:
  - m_req_o=0; granted valid_o=1 for exactly this cycle; tmo_cnt cleared; go to IDLE.
  - Requester drops or changes its request at the next edge.
  - Arbitration happens only in IDLE, so a request still high during RESP is never re-granted.
- Latency:
  - Request seen at edge 0; m_req_o high from cycle 1; ack at earliest cycle 1; valid_o at cycle 2.
  - Minimum 3 cycles per access back-to-back.
- starve_cnt:
  - Increments on each MEM grant while if_req_i=1, saturating at STARVE_MAX.
  - Clears on an IF grant or any cycle with if_req_i=0.
- ERR:
  - m_req_o=0 and err_o=1 until reset.
  - No further grants; stalls remain asserted for any held request.
  - m_ack_i is ignored.
- rdata outputs hold their last captured value until overwritten.
- Addresses and data pass through unmodified; no width conversion.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined:
  - Adds output ports perf_if_stall_o [31:0] and perf_mem_stall_o [31:0].
  - Each counter increments every cycle its stall_o=1, saturates at 32'hFFFFFFFF, and resets to 0.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- IF-only read: if_req_i=1, if_addr_i=0x40, memory acks 1 cycle after m_req_o rises with rdata=0x8C820004 -> m_addr_o=0x40, m_we_o=0, if_valid_o pulses at cycle 2, if_rdata_o=0x8C820004, if_stall_o high cycles 0–1.
- Store: mem_req_i=1, we=1, addr=0x10, wdata=0xDEADBEEF, ack after 3 cycles -> m_we_o=1, m_wdata_o=0xDEADBEEF stable throughout BUSY, mem_valid_o pulses once, mem_rdata_o unchanged.
- Simultaneous requests, held continuously, STARVE_MAX=4 -> grant order MEM, MEM, MEM, MEM, IF; if_valid_o after the 4th mem_valid_o.
- Timeout: TIMEOUT=8, m_ack_i held 0 -> ERR after 8 BUSY cycles, err_o=1, m_req_o=0, both stalls remain high; a later m_ack_i has no effect; rst_i low clears err_o.
- Reset mid-access: assert rst_i=0 during BUSY, then ack 1 cycle after release -> outputs 0 immediately, no valid pulse, FSM in IDLE, next request serviced normally.
- With ARB_PERF_CNT_EN: run the simultaneous-request scenario -> perf counters equal the observed stall-cycle counts exactly.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between IF and MEM with starvation guard and timeout trap.
// Define ARB_PERF_CNT_EN to add saturating stall-cycle counters perf_if_stall_o / perf_mem_stall_o.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int TIMEOUT    = 255,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_valid_o,
   output logic              if_stall_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic              mem_valid_o,
   output logic              mem_stall_o,
   output logic              m_req_o,
   output logic              m_we_o,
   output logic [ADDR_W-1:0] m_addr_o,
   output logic [DATA_W-1:0] m_wdata_o,
   input  logic [DATA_W-1:0] m_rdata_i,
   input  logic              m_ack_i,
   output logic              err_o
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]       perf_if_stall_o,
   output logic [31:0]       perf_mem_stall_o
`endif
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);
   typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} state_t;
   state_t            r_state, w_next;
   logic              r_gnt_if, r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata, r_if_rdata, r_mem_rdata;
   logic [TW-1:0]     r_tmo;
   logic [SW-1:0]     r_starve;
   logic              w_grant, w_pick_if, w_tmo_hit;
   logic [TW-1:0]     w_tmo_inc;
   assign w_grant   = r_state == IDLE && (if_req_i || mem_req_i);
   // MEM is the older instruction, so it wins ties unless IF has been starved
   assign w_pick_if = if_req_i && (!mem_req_i || r_starve == SW'(STARVE_MAX));
   assign w_tmo_inc = r_tmo + TW'(1);
   assign w_tmo_hit = w_tmo_inc == TW'(TIMEOUT);
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    w_next = (if_req_i || mem_req_i) ? BUSY : IDLE;
         BUSY:    w_next = m_ack_i ? RESP : (w_tmo_hit ? ERR : BUSY);
         RESP:    w_next = IDLE;
         default: w_next = ERR;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state     <= IDLE;
         r_gnt_if    <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_if_rdata  <= '0;
         r_mem_rdata <= '0;
         r_tmo       <= '0;
         r_starve    <= '0;
      end else begin
         r_state <= w_next;
         if (w_grant) begin
            r_gnt_if <= w_pick_if;
            r_addr   <= w_pick_if ? if_addr_i : mem_addr_i;
            r_we     <= !w_pick_if && mem_we_i;
            r_wdata  <= w_pick_if ? '0 : mem_wdata_i;
         end
         if (r_state == BUSY && m_ack_i && r_gnt_if)
            r_if_rdata <= m_rdata_i;
         if (r_state == BUSY && m_ack_i && !r_gnt_if && !r_we)
            r_mem_rdata <= m_rdata_i;
         r_tmo <= (r_state == BUSY && !m_ack_i) ? w_tmo_inc : (r_state == ERR ? r_tmo : '0);
         if (!if_req_i)
            r_starve <= '0;
         else if (w_grant)
            r_starve <= w_pick_if ? '0 : r_starve + SW'(1);
      end
   end
   assign m_req_o     = r_state == BUSY;
   assign m_we_o      = r_we;
   assign m_addr_o    = r_addr;
   assign m_wdata_o   = r_wdata;
   assign if_rdata_o  = r_if_rdata;
   assign mem_rdata_o = r_mem_rdata;
   assign if_valid_o  = r_state == RESP && r_gnt_if;
   assign mem_valid_o = r_state == RESP && !r_gnt_if;
   assign if_stall_o  = if_req_i && !if_valid_o;
   assign mem_stall_o = mem_req_i && !mem_valid_o;
   assign err_o       = r_state == ERR;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] r_perf_if, r_perf_mem;
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_perf_if  <= '0;
         r_perf_mem <= '0;
      end else begin
         if (if_stall_o && !(&r_perf_if))
            r_perf_if <= r_perf_if + 32'd1;
         if (mem_stall_o && !(&r_perf_mem))
            r_perf_mem <= r_perf_mem + 32'd1;
      end
   end
   assign perf_if_stall_o  = r_perf_if;
   assign perf_mem_stall_o = r_perf_mem;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a behavioural memory slave and a per-requester transaction model.
module tb_mem_port_arbiter;
   localparam int AW = 32, DW = 32, TMO = 8, SMAX = 4;
   logic          clk_i = 1'b0, rst_i = 1'b0;
   logic          if_req_i = 1'b0, mem_req_i = 1'b0, mem_we_i = 1'b0, m_ack_i = 1'b0;
   logic [AW-1:0] if_addr_i = '0, mem_addr_i = '0;
   logic [DW-1:0] mem_wdata_i = '0, m_rdata_i = '0;
   logic [DW-1:0] if_rdata_o, mem_rdata_o, m_wdata_o;
   logic [AW-1:0] m_addr_o;
   logic          if_valid_o, if_stall_o, mem_valid_o, mem_stall_o, m_req_o, m_we_o, err_o;
`ifdef ARB_PERF_CNT_EN
   logic [31:0]   perf_if_stall_o, perf_mem_stall_o;
   int unsigned   p_if = 0, p_mem = 0;
`endif

   always #5 clk_i = ~clk_i;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .STARVE_MAX(SMAX)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
      .if_valid_o(if_valid_o), .if_stall_o(if_stall_o),
      .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
      .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
      .mem_valid_o(mem_valid_o), .mem_stall_o(mem_stall_o),
      .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
      .m_rdata_i(m_rdata_i), .m_ack_i(m_ack_i), .err_o(err_o)
`ifdef ARB_PERF_CNT_EN
      , .perf_if_stall_o(perf_if_stall_o), .perf_mem_stall_o(perf_mem_stall_o)
`endif
   );

   int checks = 0, failures = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;
   exp_t        if_q[$], mem_q[$];
   int          order_q[$];
   logic [31:0] smem[logic [31:0]];
   logic [31:0] mdl[logic [31:0]];
   logic [31:0] mdl_last = '0;

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return (a == 32'h40) ? 32'h8C820004 : ((a * 32'h9E3779B1) ^ 32'h5A5A0F0F);
   endfunction

   // Behavioural memory slave: random latency, remembers the last completed bus transaction.
   bit          slave_auto = 1'b1, in_busy = 1'b0;
   int          dly = 0, lat_min = 0, lat_max = 3;
   logic [31:0] first_addr, first_wdata, log_addr, log_wdata;
   logic        first_we, log_we;
   initial forever begin
      @(posedge clk_i); #1;
      if (m_ack_i) m_ack_i = 1'b0;
      else if (m_req_o && slave_auto) begin
         if (!in_busy) begin
            in_busy = 1'b1; first_addr = m_addr_o; first_wdata = m_wdata_o; first_we = m_we_o;
         end else begin
            chk("bus_addr_stable", m_addr_o, first_addr);
            chk("bus_wdata_stable", m_wdata_o, first_wdata);
            chk("bus_we_stable", {31'b0, m_we_o}, {31'b0, first_we});
         end
         if (dly == 0) begin
            log_addr = m_addr_o; log_we = m_we_o; log_wdata = m_wdata_o;
            if (m_we_o) smem[m_addr_o] = m_wdata_o;
            m_rdata_i = m_we_o ? $urandom : (smem.exists(m_addr_o) ? smem[m_addr_o] : init_val(m_addr_o));
            m_ack_i = 1'b1; in_busy = 1'b0;
            dly = $urandom_range(lat_max, lat_min);
         end else dly--;
      end
   end

   // Monitor: pops the scoreboard whenever a completion pulse appears.
   always @(negedge clk_i) begin
      exp_t e;
      if (rst_i) begin
         chk("if_stall", {31'b0, if_stall_o}, {31'b0, if_req_i & ~if_valid_o});
         chk("mem_stall", {31'b0, mem_stall_o}, {31'b0, mem_req_i & ~mem_valid_o});
         if (if_valid_o && mem_valid_o) chk("dual_valid", 32'd1, 32'd0);
         if (if_valid_o) begin
            if (if_q.size() == 0) chk("if_valid_unexpected", 32'd1, 32'd0);
            else begin
               e = if_q.pop_front();
               chk("if_rdata", if_rdata_o, e.rdata);
               chk("if_bus_addr", log_addr, e.addr);
               chk("if_bus_we", {31'b0, log_we}, 32'd0);
               order_q.push_back(0);
            end
         end
         if (mem_valid_o) begin
            if (mem_q.size() == 0) chk("mem_valid_unexpected", 32'd1, 32'd0);
            else begin
               e = mem_q.pop_front();
               chk("mem_rdata", mem_rdata_o, e.rdata);
               chk("mem_bus_addr", log_addr, e.addr);
               chk("mem_bus_we", {31'b0, log_we}, {31'b0, e.we});
               if (e.we) chk("mem_bus_wdata", log_wdata, e.wdata);
               order_q.push_back(1);
            end
         end
`ifdef ARB_PERF_CNT_EN
         chk("perf_if", perf_if_stall_o, p_if);
         chk("perf_mem", perf_mem_stall_o, p_mem);
         if (if_stall_o) p_if++;
         if (mem_stall_o) p_mem++;
      end else begin
         p_if = 0; p_mem = 0;
`endif
      end
   end

   task automatic do_if(input logic [31:0] a, output int lat);
      exp_t e;
      e.addr = a; e.we = 1'b0; e.wdata = '0; e.rdata = init_val(a);
      if_q.push_back(e);
      if_req_i = 1'b1; if_addr_i = a; lat = 0;
      do begin @(negedge clk_i); lat++; end while (!if_valid_o && lat < 200);
      if (!if_valid_o) chk("if_wait_timeout", 32'd1, 32'd0);
      @(posedge clk_i); #1;
   endtask

   task automatic do_mem(input logic we, input logic [31:0] a, input logic [31:0] wd, output int lat);
      exp_t e;
      e.addr = a; e.we = we; e.wdata = wd;
      if (we) mdl[a] = wd;
      else mdl_last = mdl.exists(a) ? mdl[a] : init_val(a);
      e.rdata = mdl_last;
      mem_q.push_back(e);
      mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = a; mem_wdata_i = wd; lat = 0;
      do begin @(negedge clk_i); lat++; end while (!mem_valid_o && lat < 200);
      if (!mem_valid_o) chk("mem_wait_timeout", 32'd1, 32'd0);
      @(posedge clk_i); #1;
   endtask

   task automatic wait_mreq();
      int n = 0;
      while (!m_req_o && n < 20) begin @(negedge clk_i); n++; end
      chk("m_req_seen", {31'b0, m_req_o}, 32'd1);
   endtask

   int lat, la, lb, busy;
   int exp_ord[6] = '{1, 1, 1, 1, 0, 1};
   initial begin
      repeat (3) @(posedge clk_i); #1;
      chk("rst_m_req", {31'b0, m_req_o}, 32'd0);
      chk("rst_valids", {30'b0, if_valid_o, mem_valid_o}, 32'd0);
      chk("rst_err", {31'b0, err_o}, 32'd0);
      chk("rst_rdata", if_rdata_o | mem_rdata_o, 32'd0);
      chk("rst_bus", m_addr_o | m_wdata_o | {31'b0, m_we_o}, 32'd0);
      @(negedge clk_i); #2 rst_i = 1'b1;
      @(posedge clk_i); #2 m_ack_i = 1'b1;
      @(negedge clk_i);
      chk("idle_ack_ignored", {29'b0, if_valid_o, mem_valid_o, m_req_o}, 32'd0);
      @(posedge clk_i); #1;
      // IF-only fetch with minimum latency
      lat_min = 0; lat_max = 0; dly = 0;
      do_if(32'h40, lat);
      chk("if_latency", lat, 3);
      if_req_i = 1'b0;
      // store acked after three BUSY cycles
      lat_min = 2; lat_max = 2; dly = 2;
      do_mem(1'b1, 32'h10, 32'hDEADBEEF, lat);
      chk("store_latency", lat, 5);
      chk("if_rdata_hold", if_rdata_o, 32'h8C820004);
      lat_min = 0; lat_max = 3; dly = 1;
      do_mem(1'b0, 32'h10, 32'h0, lat);
      mem_req_i = 1'b0;
      // both held continuously: four MEM grants then a forced IF grant
      @(posedge clk_i); #1;
      order_q.delete();
      fork
         begin do_if(32'h1000_0100, la); if_req_i = 1'b0; end
         begin
            for (int k = 0; k < 5; k++) do_mem(k[0], 32'h100 + 4 * k, $urandom, lb);
            mem_req_i = 1'b0;
         end
      join
      chk("grant_order_len", order_q.size(), 6);
      for (int k = 0; k < 6; k++)
         if (k < order_q.size()) chk("grant_order", order_q[k], exp_ord[k]);
      // randomized concurrent traffic
      fork
         for (int i = 0; i < 25; i++) begin
            int g = $urandom_range(3, 0);
            if (g != 0) begin if_req_i = 1'b0; repeat (g) @(posedge clk_i); #1; end
            do_if(32'h1000_0000 + 4 * $urandom_range(63, 0), la);
         end
         for (int i = 0; i < 25; i++) begin
            int g = $urandom_range(3, 0);
            if (g != 0) begin mem_req_i = 1'b0; repeat (g) @(posedge clk_i); #1; end
            do_mem(1'($urandom_range(1, 0)), 32'h100 + 4 * $urandom_range(7, 0), $urandom, lb);
         end
      join
      if_req_i = 1'b0; mem_req_i = 1'b0;
      chk("if_q_drained", if_q.size(), 0);
      chk("mem_q_drained", mem_q.size(), 0);
      // timeout trap
      slave_auto = 1'b0;
      @(posedge clk_i); #1;
      if_req_i = 1'b1; if_addr_i = 32'h1000_0200;
      mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h104;
      wait_mreq();
      busy = 0;
      while (m_req_o && busy < 50) begin busy++; @(negedge clk_i); end
      chk("tmo_busy_cycles", busy, TMO);
      chk("tmo_err", {31'b0, err_o}, 32'd1);
      chk("tmo_m_req", {31'b0, m_req_o}, 32'd0);
      chk("tmo_stalls", {30'b0, if_stall_o, mem_stall_o}, 32'd3);
      @(posedge clk_i); #2 m_ack_i = 1'b1; m_rdata_i = 32'h0BAD_0BAD;
      repeat (3) @(negedge clk_i);
      chk("err_sticky", {31'b0, err_o}, 32'd1);
      chk("err_rdata_hold", mem_rdata_o, mdl_last);
      #2 rst_i = 1'b0;
      #1 chk("err_cleared", {30'b0, err_o, m_req_o}, 32'd0);
      if_req_i = 1'b0; mem_req_i = 1'b0; mdl_last = '0;
      @(negedge clk_i); #2 rst_i = 1'b1;
      // reset during an access
      @(posedge clk_i); #1;
      mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h108;
      wait_mreq();
      @(negedge clk_i); #2 rst_i = 1'b0;
      #1 chk("midrst_outs", {29'b0, m_req_o, mem_valid_o, err_o} | m_addr_o | mem_rdata_o, 32'd0);
      mem_req_i = 1'b0;
      @(negedge clk_i); #2 rst_i = 1'b1;
      @(posedge clk_i); #2 m_ack_i = 1'b1;
      repeat (3) begin
         @(negedge clk_i);
         chk("midrst_no_valid", {29'b0, if_valid_o, mem_valid_o, m_req_o}, 32'd0);
      end
      slave_auto = 1'b1; in_busy = 1'b0; dly = 0;
      @(posedge clk_i); #1;
      do_mem(1'b0, 32'h108, 32'h0, lat);
      mem_req_i = 1'b0;
      do_if(32'h1000_0004, lat);
      if_req_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("final_if_q", if_q.size(), 0);
      chk("final_mem_q", mem_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
